// File: rtl/seq_pattern_generator.sv
// rtl/seq_pattern_generator.sv - repeating MSB-first serial pattern generator; SEQ_GEN_PARITY_EN adds a parity bit per repetition
module seq_pattern_generator #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter int               REP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] pat_in,
    input  logic             start,
    input  logic [REP_W-1:0] count,
    input  logic             stall,
    output logic             serial_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    localparam int               IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

`ifdef SEQ_GEN_PARITY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pat_reg, tx_pat, start_pat;
    logic [REP_W-1:0] count_lat, rep_cnt;
    logic [IDX_W-1:0] bit_idx, idx_dn;
    logic             last_bit, last_rep;
    logic             serial_nxt, valid_nxt, busy_nxt, done_nxt;

    // A load in the start cycle overrides the stored pattern for this transmission
    assign start_pat = load ? pat_in : pat_reg;
    assign idx_dn    = bit_idx - 1'b1;
    assign last_bit  = (bit_idx == '0);
    assign last_rep  = (rep_cnt == count_lat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = start ? S_SHIFT : S_IDLE;
            S_SHIFT: begin
                if (stall || !last_bit)
                    state_nxt = S_SHIFT;
`ifdef SEQ_GEN_PARITY_EN
                else
                    state_nxt = S_PARITY;
`else
                else
                    state_nxt = last_rep ? S_DONE : S_SHIFT;
`endif
            end
`ifdef SEQ_GEN_PARITY_EN
            S_PARITY: begin
                if (stall)         state_nxt = S_PARITY;
                else if (last_rep) state_nxt = S_DONE;
                else               state_nxt = S_SHIFT;
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; stall re-presents the current ones
    always_comb begin
        serial_nxt = 1'b0;
        valid_nxt  = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    serial_nxt = start_pat[WIDTH-1];
                    valid_nxt  = 1'b1;
                    busy_nxt   = 1'b1;
                end
            end
            S_SHIFT: begin
                if (stall) begin
                    serial_nxt = serial_out;
                    valid_nxt  = out_valid;
                    busy_nxt   = busy;
                end else if (!last_bit) begin
                    serial_nxt = tx_pat[idx_dn];
                    valid_nxt  = 1'b1;
                    busy_nxt   = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
                end else begin
                    serial_nxt = ^tx_pat;
                    valid_nxt  = 1'b1;
                    busy_nxt   = 1'b1;
                end
`else
                end else if (!last_rep) begin
                    serial_nxt = tx_pat[WIDTH-1];
                    valid_nxt  = 1'b1;
                    busy_nxt   = 1'b1;
                end else begin
                    done_nxt   = 1'b1;
                end
`endif
            end
`ifdef SEQ_GEN_PARITY_EN
            S_PARITY: begin
                if (stall) begin
                    serial_nxt = serial_out;
                    valid_nxt  = out_valid;
                    busy_nxt   = busy;
                end else if (!last_rep) begin
                    serial_nxt = tx_pat[WIDTH-1];
                    valid_nxt  = 1'b1;
                    busy_nxt   = 1'b1;
                end else begin
                    done_nxt   = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serial_out <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            serial_out <= serial_nxt;
            out_valid  <= valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_reg   <= PATTERN;
            tx_pat    <= PATTERN;
            count_lat <= '0;
            bit_idx   <= '0;
            rep_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) pat_reg <= pat_in;
                    if (start) begin
                        tx_pat    <= start_pat;
                        count_lat <= count;
                        bit_idx   <= MSB_IDX;
                        rep_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (!stall && !last_bit) begin
                        bit_idx <= idx_dn;
`ifndef SEQ_GEN_PARITY_EN
                    end else if (!stall && !last_rep) begin
                        bit_idx <= MSB_IDX;
                        rep_cnt <= rep_cnt + 1'b1;
`endif
                    end
                end
`ifdef SEQ_GEN_PARITY_EN
                S_PARITY: begin
                    if (!stall && !last_rep) begin
                        bit_idx <= MSB_IDX;
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_generator.sv
// tb/tb_seq_pattern_generator.sv - directed and randomized bench for seq_pattern_generator against a stream model
module tb_seq_pattern_generator;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] pat_in = 4'd0;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic       stall = 1'b0;
    logic       serial_out, out_valid, busy, done;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] model_pat = 4'b1011;
    int         done_cyc;

    seq_pattern_generator dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .pat_in     (pat_in),
        .start      (start),
        .count      (count),
        .stall      (stall),
        .serial_out (serial_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_serial"}, serial_out, 0);
        chk({tag, "_valid"},  out_valid,  0);
        chk({tag, "_busy"},   busy,       0);
        chk({tag, "_done"},   done,       0);
    endtask

    // Called at a negedge; start is sampled at the next rising edge (cycle 0 ends there)
    task automatic run_tx(input string tag, input logic [3:0] pat_arg, input bit with_load,
                          input int cnt, input logic [63:0] mask, input int pct,
                          input bit noise, output int dcyc);
        logic [3:0] tx;
        bit         q[$];
        int         idx;
        int         cyc;
        bit         st;
        tx = with_load ? pat_arg : model_pat;
        if (with_load) model_pat = pat_arg;
        for (int r = 0; r <= cnt; r++) begin
            for (int b = 3; b >= 0; b--) q.push_back(tx[b]);
`ifdef SEQ_GEN_PARITY_EN
            q.push_back(^tx);
`endif
        end
        start  = 1'b1;
        load   = with_load;
        pat_in = pat_arg;
        count  = 4'(cnt);
        stall  = (pct > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
        idx   = 0;
        cyc   = 1;
        dcyc  = -1;
        while (idx < q.size()) begin
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_bit"},   serial_out, q[idx]);
            chk({tag, "_busy"},  busy, 1);
            chk({tag, "_done"},  done, 0);
            st    = ((cyc < 64) && mask[cyc]) || ($urandom_range(0, 99) < pct);
            stall = st;
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                load   = 1'($urandom_range(0, 1));
                pat_in = 4'($urandom);
                count  = 4'($urandom);
            end
            if (!st) idx++;
            @(negedge clk);
            cyc++;
            if (cyc > 1500) begin
                chk({tag, "_timeout"}, 1, 0);
                break;
            end
        end
        chk({tag, "_done_pulse"}, done, 1);
        chk({tag, "_done_valid"}, out_valid, 0);
        chk({tag, "_done_busy"},  busy, 0);
        chk({tag, "_done_serial"}, serial_out, 0);
        dcyc = cyc;
        stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
        stall = 1'b0;
        chk_quiet({tag, "_idle"});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b0;

        // Start right after reset release, single repetition of the reset pattern
        run_tx("first", 4'd0, 1'b0, 0, 64'd0, 0, 1'b0, done_cyc);
`ifdef SEQ_GEN_PARITY_EN
        chk("first_done_cycle", done_cyc, 6);
`else
        chk("first_done_cycle", done_cyc, 5);
`endif

        // Load alone produces no output, then three back-to-back repetitions
        load   = 1'b1;
        pat_in = 4'b0110;
        model_pat = 4'b0110;
        @(negedge clk);
        load = 1'b0;
        chk_quiet("load_only");
        run_tx("rep3", 4'd0, 1'b0, 2, 64'd0, 0, 1'b0, done_cyc);
`ifndef SEQ_GEN_PARITY_EN
        chk("rep3_done_cycle", done_cyc, 13);
`endif

        // Extra start while busy is ignored; reset mid-transmission aborts without done
        start = 1'b1;
        count = 4'd3;
        @(negedge clk);
        start = 1'b0;
        chk("abort_c1_bit", serial_out, model_pat[3]);
        @(negedge clk);
        chk("abort_c2_bit", serial_out, model_pat[2]);
        start  = 1'b1;
        load   = 1'b1;
        pat_in = 4'b0001;
        @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
        chk("abort_c3_bit", serial_out, model_pat[1]);
        chk("abort_c3_busy", busy, 1);
        #2 reset = 1'b1;
        #1 chk_quiet("abort_async");
        @(negedge clk);
        chk_quiet("abort_held");
        reset = 1'b0;
        model_pat = 4'b1011;
        @(negedge clk);
        chk_quiet("abort_no_done");

        // Default pattern with stall in cycles 2-3
        run_tx("stall", 4'd0, 1'b0, 0, 64'b1100, 0, 1'b0, done_cyc);
`ifndef SEQ_GEN_PARITY_EN
        chk("stall_done_cycle", done_cyc, 7);
`endif

        // Two repetitions (parity stream when enabled)
        run_tx("count1", 4'd0, 1'b0, 1, 64'd0, 0, 1'b0, done_cyc);

        // Load and start together: stream uses pat_in and the register keeps it
        run_tx("ldst", 4'b1100, 1'b1, 0, 64'd0, 0, 1'b0, done_cyc);
        run_tx("ldst_kept", 4'd0, 1'b0, 0, 64'd0, 0, 1'b0, done_cyc);

        // All-ones count: 16 repetitions
        run_tx("maxcnt", 4'b1001, 1'b1, 15, 64'd0, 0, 1'b0, done_cyc);

        for (int i = 0; i < 16; i++) begin
            run_tx("rand", 4'($urandom), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3)),
                   64'd0, 30, 1'b1, done_cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
